// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, waits RD_LATENCY cycles per fetch, and
// queues {PC, word} in a 2-entry FIFO presented to decode over valid/ready.
module fetch_unit #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] InstAddr,
  input  logic [31:0] InstData,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic        InstValid,
  output logic [31:0] InstOut,
  output logic [63:0] InstPC,
  input  logic        InstReady
);

  typedef enum logic {S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] LAST = 4'(RD_LATENCY - 1);
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  state_t      state_q;
  logic [63:0] pc_q;
  logic [3:0]  cnt_q;
  logic [1:0]  fill_q;
  logic [31:0] data_q [2];
  logic [63:0] epc_q  [2];

  logic        pop;
  logic        full;
  logic        due;
  logic        capture;
  logic [63:0] pc_d;
  logic [63:0] redir_pc_d;

  assign pop        = (fill_q != 2'd0) && InstReady;
  assign full       = (fill_q == FULL);
  assign due        = (state_q == S_HOLD) || (cnt_q == LAST);
  assign capture    = due && (!full || pop);
  assign pc_d       = pc_q + 64'd4;
  assign redir_pc_d = RedirectPC & ~64'h3;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_WAIT;
      pc_q      <= RESET_PC;
      cnt_q     <= 4'd0;
      fill_q    <= 2'd0;
      data_q[0] <= 32'h0;
      data_q[1] <= 32'h0;
      epc_q[0]  <= 64'h0;
      epc_q[1]  <= 64'h0;
    end else if (Redirect) begin
      // Entry 0 is left untouched so the outputs keep their last value.
      state_q <= S_WAIT;
      pc_q    <= redir_pc_d;
      cnt_q   <= 4'd0;
      fill_q  <= 2'd0;
    end else begin
      if (capture) begin
        pc_q    <= pc_d;
        cnt_q   <= 4'd0;
        state_q <= S_WAIT;
      end else if (due) begin
        state_q <= S_HOLD;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end

      // Entry 0 is always the head; a pop shifts entry 1 forward.
      case ({capture, pop})
        2'b10: begin
          if (fill_q == 2'd0) begin
            data_q[0] <= InstData;
            epc_q[0]  <= pc_q;
          end else begin
            data_q[1] <= InstData;
            epc_q[1]  <= pc_q;
          end
          fill_q <= fill_q + 2'd1;
        end
        2'b01: begin
          if (fill_q == 2'd2) begin
            data_q[0] <= data_q[1];
            epc_q[0]  <= epc_q[1];
          end
          fill_q <= fill_q - 2'd1;
        end
        2'b11: begin
          if (fill_q == 2'd1) begin
            data_q[0] <= InstData;
            epc_q[0]  <= pc_q;
          end else begin
            data_q[0] <= data_q[1];
            epc_q[0]  <= epc_q[1];
            data_q[1] <= InstData;
            epc_q[1]  <= pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign InstAddr  = pc_q;
  assign InstValid = (fill_q != 2'd0);
  assign InstOut   = data_q[0];
  assign InstPC    = epc_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances (latency 1, latency 3, wrapping reset PC),
// each tracked by a queue-based model and checked every cycle, plus directed literals.
module tb_fetch_unit;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] d;
  } ent_t;

  logic        CLK;
  logic [2:0]  rst;
  logic        ready;
  logic        redir;
  logic [63:0] rpc;

  logic [63:0] addr  [3];
  logic [31:0] dat   [3];
  logic        valid [3];
  logic [31:0] out   [3];
  logic [63:0] ipc   [3];

  int total = 0;
  int bad   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] r;
    case (a)
      64'h28:  r = 32'h17FF_FFFD;
      64'h34:  r = 32'hD2E2_4689;
      default: r = 32'hF840_03E9 + 32'(a[31:2]) * 32'h0000_8001;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned LAT = (g == 1) ? 3 : 1;
    localparam logic [63:0] RPC = (g == 2) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h0;

    assign dat[g] = mem_word(addr[g]);

    fetch_unit #(
      .RD_LATENCY(LAT),
      .RESET_PC  (RPC),
      .BUF_DEPTH (2)
    ) u_dut (
      .CLK       (CLK),
      .Reset     (rst[g]),
      .InstAddr  (addr[g]),
      .InstData  (dat[g]),
      .Redirect  (redir),
      .RedirectPC(rpc),
      .InstValid (valid[g]),
      .InstOut   (out[g]),
      .InstPC    (ipc[g]),
      .InstReady (ready)
    );

    ent_t        q[$];
    ent_t        shown;
    logic [63:0] m_pc;
    int          held;
    bit          armed = 0;
    logic [63:0] last_pop = '0;
    int          delivered = 0;

    // Model: PC held for LAT cycles then captured if the FIFO has room after any pop.
    initial begin
      forever begin
        @(posedge CLK);
        if (rst[g]) begin
          m_pc  = RPC;
          held  = 0;
          q.delete();
          shown = '0;
          armed = 1;
        end else if (armed) begin
          if (q.size() > 0 && ready) begin
            last_pop = q[0].pc;
            delivered++;
            void'(q.pop_front());
          end
          if (redir) begin
            q.delete();
            m_pc = {rpc[63:2], 2'b00};
            held = 0;
          end else begin
            held++;
            if (held >= int'(LAT)) begin
              if (q.size() < 2) begin
                q.push_back('{pc: m_pc, d: mem_word(m_pc)});
                m_pc = m_pc + 64'd4;
                held = 0;
              end else begin
                held = LAT;
              end
            end
          end
          if (q.size() > 0) shown = q[0];
        end
      end
    end

    initial begin
      forever begin
        @(negedge CLK);
        if (armed) begin
          chk($sformatf("u%0d.InstAddr", g),  addr[g], m_pc);
          chk($sformatf("u%0d.InstValid", g), 64'(valid[g]), 64'(q.size() > 0));
          chk($sformatf("u%0d.InstOut", g),   64'(out[g]), 64'(shown.d));
          chk($sformatf("u%0d.InstPC", g),    ipc[g], shown.pc);
        end
      end
    end
  end

  initial begin
    rst   = 3'b111;
    ready = 1'b1;
    redir = 1'b0;
    rpc   = 64'h0;

    // Reset state and streaming at latency 1
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_addr",  addr[0], 64'h0);
    chk("rst_valid", 64'(valid[0]), 64'h0);
    chk("rst_out",   64'(out[0]), 64'h0);
    chk("rst_pc",    ipc[0], 64'h0);
    rst[0] = 1'b0;
    @(negedge CLK);
    chk("s0_valid", 64'(valid[0]), 64'h1);
    chk("s0_pc",    ipc[0], 64'h0);
    chk("s0_out",   64'(out[0]), 64'hF840_03E9);
    @(negedge CLK);
    chk("s1_pc",  ipc[0], 64'h4);
    chk("s1_out", 64'(out[0]), 64'hF840_83EA);
    @(negedge CLK);
    chk("s2_pc",  ipc[0], 64'h8);
    chk("s2_out", 64'(out[0]), 64'hF841_03EB);

    // Stall from reset: FIFO fills, address holds
    rst[0] = 1'b1;
    ready  = 1'b0;
    @(negedge CLK);
    rst[0] = 1'b0;
    repeat (6) @(negedge CLK);
    chk("hold_addr",  addr[0], 64'h8);
    chk("hold_valid", 64'(valid[0]), 64'h1);
    chk("hold_head",  ipc[0], 64'h0);
    ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("drain%0d_pc", i), ipc[0], 64'(4 * i));
    end

    // Redirect with two buffered entries and decode stalled
    ready = 1'b0;
    redir = 1'b1;
    rpc   = 64'h28;
    @(negedge CLK);
    redir = 1'b0;
    chk("rd1_valid", 64'(valid[0]), 64'h0);
    chk("rd1_addr",  addr[0], 64'h28);
    @(negedge CLK);
    chk("rd1_nvalid", 64'(valid[0]), 64'h1);
    chk("rd1_pc",     ipc[0], 64'h28);
    chk("rd1_out",    64'(out[0]), 64'h17FF_FFFD);
    @(negedge CLK);
    chk("rd1_stay", ipc[0], 64'h28);

    // Misaligned redirect with a same-edge pop of PC 0x10
    redir = 1'b1;
    rpc   = 64'h10;
    @(negedge CLK);
    redir = 1'b0;
    @(negedge CLK);
    chk("rd2_head", ipc[0], 64'h10);
    ready = 1'b1;
    redir = 1'b1;
    rpc   = 64'h36;
    @(negedge CLK);
    redir = 1'b0;
    chk("rd2_valid",   64'(valid[0]), 64'h0);
    chk("rd2_addr",    addr[0], 64'h34);
    chk("rd2_popped",  g_inst[0].last_pop, 64'h10);
    @(negedge CLK);
    chk("rd2_nvalid", 64'(valid[0]), 64'h1);
    chk("rd2_pc",     ipc[0], 64'h34);
    chk("rd2_out",    64'(out[0]), 64'hD2E2_4689);

    // Latency 3, then reset with counter at 1
    rst[1] = 1'b0;
    @(negedge CLK);
    chk("l3_c1_valid", 64'(valid[1]), 64'h0);
    chk("l3_c1_addr",  addr[1], 64'h0);
    @(negedge CLK);
    chk("l3_c2_valid", 64'(valid[1]), 64'h0);
    @(negedge CLK);
    chk("l3_c3_valid", 64'(valid[1]), 64'h1);
    chk("l3_c3_pc",    ipc[1], 64'h0);
    chk("l3_c3_out",   64'(out[1]), 64'hF840_03E9);
    chk("l3_c3_addr",  addr[1], 64'h4);
    @(negedge CLK);
    chk("l3_c4_valid", 64'(valid[1]), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("l3_c6_valid", 64'(valid[1]), 64'h1);
    chk("l3_c6_pc",    ipc[1], 64'h4);
    @(negedge CLK);
    chk("l3_c7_valid", 64'(valid[1]), 64'h0);
    rst[1] = 1'b1;
    @(negedge CLK);
    rst[1] = 1'b0;
    chk("l3_rst_valid", 64'(valid[1]), 64'h0);
    chk("l3_rst_addr",  addr[1], 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("l3_r2_valid", 64'(valid[1]), 64'h0);
    @(negedge CLK);
    chk("l3_r3_valid", 64'(valid[1]), 64'h1);
    chk("l3_r3_pc",    ipc[1], 64'h0);

    // PC wrap from the top of the address space
    rst[2] = 1'b0;
    @(negedge CLK);
    chk("wrap_pc0",  ipc[2], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr", addr[2], 64'h0);
    @(negedge CLK);
    chk("wrap_pc1", ipc[2], 64'h0);
    chk("wrap_out", 64'(out[2]), 64'hF840_03E9);

    repeat (8) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the 64-bit PC and drives the memory address.
- Waits a fixed read latency, then captures the returned 32-bit word with its PC into a 2-entry buffer.
- Presents buffered instructions to decode over a valid/ready handshake and accepts redirects from branch/CBZ resolution.

Parameters:
- RD_LATENCY, 1: cycles the address must be held stable before InstData is sampled; legal range 1..15.
- RESET_PC, 64'h0: PC loaded on reset.
- BUF_DEPTH, 2: buffer entries; fixed at 2, other values unsupported.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- InstAddr  out  64  address to instruction memory; equals the internal PC register.
- InstData  in  32  instruction word returned by memory.
- Redirect  in  1  taken branch/CBZ; flush and refetch.
- RedirectPC  in  64  redirect target.
- InstValid  out  1  buffer head holds a valid instruction.
- InstOut  out  32  instruction at buffer head.
- InstPC  out  64  PC of instruction at buffer head.
- InstReady  in  1  decode accepts the head this cycle.

Behaviour:
- Reset is synchronous and active-high, sampled on the CLK rising edge. Reset state:
  - PC=RESET_PC, latency counter=0, buffer empty.
  - InstValid=0, InstOut=32'h0, InstPC=64'h0.
- Reset overrides Redirect and any handshake in the same cycle, and aborts any fetch in progress.
- States:
  - WAIT: counter counts the cycles the address has been held.
  - HOLD: latency satisfied but buffer full; address held.
- Capture rule:
  - In the cycle where counter==RD_LATENCY-1, or in HOLD, capture {PC, InstData} at the edge if the buffer has space.
  - Space exists when the buffer is not full, or when it is full and a pop occurs in the same cycle.
  - On capture: PC<=PC+4, counter<=0, state WAIT.
  - No space: state HOLD, PC and counter unchanged.
- Throughput is one instruction per RD_LATENCY cycles when unstalled.
- PC addition is modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0).
- Pop: InstValid&&InstReady at an edge removes the head. The next entry appears the following cycle. Order is strictly FIFO.
- Capture into an empty buffer appears on the outputs the cycle after the capture edge. There is no combinational bypass from InstData to InstOut.
- InstOut/InstPC hold their last value when InstValid=0 (and are 0 after reset).
- InstValid must never drop while InstReady=0, except on Redirect or Reset.
- Redirect (priority below Reset, above everything else):
  - Redirect target: PC<={RedirectPC[63:2],2'b00}; misaligned targets are silently aligned.
  - Fetch restart: counter<=0, state WAIT. Any in-flight fetch is discarded; no capture occurs on the redirect edge.
  - Buffer flush: all entries are flushed.
  - A head popped on the same edge counts as delivered.
  - InstValid=0 the cycle after a redirect.
- Redirect while buffer empty or in HOLD: same behaviour, no special case.
- InstAddr is registered; it changes only at edges.

Test Plan:
- Reset 2 cycles, RD_LATENCY=1, InstReady=1 → InstAddr=0 in the first cycle after reset; InstValid=1 the next cycle with InstPC=0, InstOut=32'hF84003E9; then PC 4/32'hF84083EA and PC 8/32'hF84103EB on consecutive cycles.
- InstReady=0 from reset for 6 cycles → buffer holds PC 0 and 4, InstAddr stuck at 8 (HOLD). Raise InstReady → PCs 0,4,8,0xC delivered on consecutive cycles with no loss or duplication.
- Redirect=1, RedirectPC=0x28 while 2 entries buffered and InstReady=0 → next cycle InstValid=0, InstAddr=0x28. The following cycle InstValid=1, InstPC=0x28, InstOut=32'h17FFFFFD; the old entries never appear.
- Redirect with RedirectPC=0x36 and a same-cycle pop of PC 0x10 → PC 0x10 counted delivered, InstAddr=0x34, then InstOut=32'hD2E24689 at InstPC=0x34.
- RD_LATENCY=3 → first InstValid 3 cycles after address 0 is driven; subsequent instructions every 3 cycles. Reset asserted mid-WAIT (counter=1) → InstValid=0, InstAddr=RESET_PC next cycle, counter restarts from 0.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second fetch address is 0; InstPC sequence FFFF_FFFF_FFFF_FFFC, 0.
